// File: rtl/servo_slew_ctrl.sv
// Rate-limited servo position controller: buffers one target, steps pwm_cmd toward it once per frame.
// Optional feature macro: SERVO_WATCHDOG_EN parks the servo at CENTER after WDOG_FRAMES idle frames.
module servo_slew_ctrl #(
    parameter int FRAME_CYCLES  = 2000000,
    parameter int STEP          = 4,
    parameter int DEADBAND      = 2,
    parameter int POS_MIN       = 0,
    parameter int POS_MAX       = 254,
    parameter int CENTER        = 127,
    parameter int SETTLE_FRAMES = 3,
    parameter int WDOG_FRAMES   = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] target,
    input  logic       target_valid,
    output logic       target_ready,
    output logic [7:0] pwm_cmd,
    output logic       frame_tick,
    output logic       at_target,
    output logic       busy,
    output logic       wdog_flag
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int SET_W = $clog2(SETTLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_FRAMES - 1);
    localparam logic [7:0] STEP_C     = 8'(STEP);
    localparam logic [7:0] DEADBAND_C = 8'(DEADBAND);
    localparam logic [7:0] POS_MIN_C  = 8'(POS_MIN);
    localparam logic [7:0] POS_MAX_C  = 8'(POS_MAX);
    localparam logic [7:0] CENTER_C   = 8'(CENTER);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SLEW   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_tick_q, frame_tick_d;
    logic [7:0]       pwm_q, pwm_d;
    logic [7:0]       goal_q, goal_d;
    logic [7:0]       pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [SET_W-1:0] settle_q, settle_d;
    state_t           state_q, state_d;
    logic             xfer_s;
    logic             near_s;
    logic [7:0]       clamped_s;
    logic             wdog_park_s;

    function automatic logic [7:0] clamp_pos(input logic [7:0] v);
        if (v < POS_MIN_C) begin
            clamp_pos = POS_MIN_C;
        end else if (v > POS_MAX_C) begin
            clamp_pos = POS_MAX_C;
        end else begin
            clamp_pos = v;
        end
    endfunction

    // Magnitude of a - b, evaluated as a 9-bit signed difference.
    function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d < 9'sd0) begin
            abs_diff = 9'(-d);
        end else begin
            abs_diff = 9'(d);
        end
    endfunction

    function automatic logic [7:0] step_toward(input logic [7:0] pos, input logic [7:0] goal);
        if (abs_diff(goal, pos) <= {1'b0, STEP_C}) begin
            step_toward = goal;
        end else if (goal > pos) begin
            step_toward = pos + STEP_C;
        end else begin
            step_toward = pos - STEP_C;
        end
    endfunction

    assign xfer_s    = target_valid && !pend_full_q;
    assign clamped_s = clamp_pos(target);
    assign near_s    = (abs_diff(clamped_s, goal_q) <= {1'b0, DEADBAND_C});

    // Frame timing, target buffering, slew stepping and mode sequencing.
    always_comb begin
        cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        frame_tick_d = (cnt_q == CNT_LAST);
        pwm_d        = pwm_q;
        goal_d       = goal_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        settle_d     = settle_q;
        state_d      = state_q;

        if (frame_tick_q) begin
            // Step uses the goal held before this tick's reload.
            pwm_d = step_toward(pwm_q, goal_q);
            if (pend_full_q) begin
                goal_d      = pend_q;
                pend_full_d = 1'b0;
            end else if (wdog_park_s) begin
                goal_d = CENTER_C;
            end else begin
                goal_d = goal_q;
            end
        end else begin
            pwm_d = pwm_q;
        end

        if (xfer_s && !near_s) begin
            pend_d      = clamped_s;
            pend_full_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_tick_q && (goal_q != pwm_q)) begin
                    state_d = ST_SLEW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SLEW: begin
                if (frame_tick_q && (pwm_d == goal_q)) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end else begin
                    state_d = ST_SLEW;
                end
            end
            ST_SETTLE: begin
                if (!frame_tick_q) begin
                    state_d = ST_SETTLE;
                end else if (goal_q != pwm_q) begin
                    state_d = ST_SLEW;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_IDLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                settle_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset to the parked, idle condition.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            frame_tick_q <= 1'b0;
            pwm_q        <= CENTER_C;
            goal_q       <= CENTER_C;
            pend_q       <= 8'd0;
            pend_full_q  <= 1'b0;
            settle_q     <= '0;
            state_q      <= ST_IDLE;
        end else begin
            cnt_q        <= cnt_d;
            frame_tick_q <= frame_tick_d;
            pwm_q        <= pwm_d;
            goal_q       <= goal_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            settle_q     <= settle_d;
            state_q      <= state_d;
        end
    end

`ifdef SERVO_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_FRAMES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_FRAMES - 1);

    logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic            wdog_flag_q, wdog_flag_d;

    // Any handshake (stored or dropped) restarts the idle-frame count.
    always_comb begin
        wdog_cnt_d  = wdog_cnt_q;
        wdog_flag_d = wdog_flag_q;
        wdog_park_s = 1'b0;
        if (xfer_s) begin
            wdog_cnt_d  = '0;
            wdog_flag_d = 1'b0;
        end else if (frame_tick_q) begin
            if (wdog_cnt_q == WD_LAST) begin
                wdog_park_s = 1'b1;
                wdog_cnt_d  = '0;
                wdog_flag_d = 1'b1;
            end else begin
                wdog_cnt_d = wdog_cnt_q + WD_W'(1);
            end
        end else begin
            wdog_cnt_d = wdog_cnt_q;
        end
    end

    // Watchdog count and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt_q  <= '0;
            wdog_flag_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_flag_q <= wdog_flag_d;
        end
    end

    assign wdog_flag = wdog_flag_q;
`else
    localparam int unused_wdog_frames = WDOG_FRAMES;
    assign wdog_park_s = 1'b0;
    assign wdog_flag   = 1'b0;
`endif

    assign target_ready = !pend_full_q;
    assign pwm_cmd      = pwm_q;
    assign frame_tick   = frame_tick_q;
    assign at_target    = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_SLEW) || (state_q == ST_SETTLE);

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Scoreboard bench for servo_slew_ctrl with 100-cycle frames; expected per-tick outputs are queued by stimulus.
module tb_servo_slew_ctrl;

    localparam int FRAME = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] target;
    logic       target_valid;
    logic       target_ready;
    logic [7:0] pwm_cmd;
    logic       frame_tick;
    logic       at_target;
    logic       busy;
    logic       wdog_flag;

    typedef struct {
        int pwm;
        int at;
        int bsy;
        int wd;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    servo_slew_ctrl #(.FRAME_CYCLES(FRAME)) dut (
        .clk         (clk),
        .reset       (reset),
        .target      (target),
        .target_valid(target_valid),
        .target_ready(target_ready),
        .pwm_cmd     (pwm_cmd),
        .frame_tick  (frame_tick),
        .at_target   (at_target),
        .busy        (busy),
        .wdog_flag   (wdog_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic push(input int pwm, input int at, input int bsy, input int wd);
        exp_t e;
        e.pwm = pwm; e.at = at; e.bsy = bsy; e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!frame_tick && guard < 3 * FRAME);
            if (!frame_tick) chk("tick_timeout", 0, 1);
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] v);
        target       = v;
        target_valid = 1'b1;
        @(negedge clk);
        target_valid = 1'b0;
    endtask

    // Monitor: compares the queued expectation in the cycle following each frame tick.
    initial begin
        bit chk_pend = 1'b0;
        int cyc = 0;
        int last_tick = -1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk_pend  = 1'b0;
                last_tick = -1;
            end else begin
                cyc++;
                if (chk_pend && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_pwm_cmd", int'(pwm_cmd), e.pwm);
                    chk("sb_at_target", int'(at_target), e.at);
                    chk("sb_busy", int'(busy), e.bsy);
                    chk("sb_wdog_flag", int'(wdog_flag), e.wd);
                end
                chk_pend = frame_tick;
                if (frame_tick) begin
                    if (last_tick >= 0) chk("tick_period", cyc - last_tick, FRAME);
                    last_tick = cyc;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        target       = 8'd0;
        target_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(pwm_cmd), 127);
        chk("rst_at_target", int'(at_target), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(target_ready), 1);
        chk("rst_tick", int'(frame_tick), 0);
        chk("rst_wdog", int'(wdog_flag), 0);
        reset = 1'b0;

        // Idle frames at centre.
        for (int i = 0; i < 5; i++) push(127, 1, 0, 0);
        wait_ticks(5);

        // Slew to 200: reload on first tick, step from the second.
        push(127, 1, 0, 0);
        for (int k = 1; k <= 18; k++) push(127 + 4 * k, 0, 1, 0);
        for (int i = 0; i < 3; i++) push(200, 0, 1, 0);
        for (int i = 0; i < 2; i++) push(200, 1, 0, 0);
        send(8'd200);
        chk("accept_ready_low", int'(target_ready), 0);
        wait_ticks(24);

        // 255 clamps to 254.
        push(200, 1, 0, 0);
        for (int k = 1; k <= 13; k++) push(200 + 4 * k, 0, 1, 0);
        for (int i = 0; i < 3; i++) push(254, 0, 1, 0);
        push(254, 1, 0, 0);
        send(8'd255);
        chk("clamp_ready_low", int'(target_ready), 0);
        wait_ticks(18);

        // Inside deadband: handshaken and dropped.
        push(254, 1, 0, 0);
        send(8'd253);
        chk("deadband_ready", int'(target_ready), 1);
        wait_ticks(1);

        // Back-to-back 10 then 20: 20 stalls until the tick that loads 10.
        push(254, 1, 0, 0);
        for (int k = 1; k <= 26; k++) push(254 - 4 * k, 0, 1, 0);
        target       = 8'd10;
        target_valid = 1'b1;
        @(negedge clk);
        target = 8'd20;
        chk("stall_ready_low", int'(target_ready), 0);
        begin
            int stall = 0;
            while (!target_ready && stall < 3 * FRAME) begin
                @(negedge clk);
                stall++;
            end
            chk("stall_released", int'(target_ready), 1);
        end
        @(negedge clk);
        target_valid = 1'b0;
        chk("second_held", int'(target_ready), 0);
        wait_ticks(26);
        @(negedge clk);

        // Reset mid-slew at pwm_cmd = 150.
        chk("pre_reset_pwm", int'(pwm_cmd), 150);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_pwm", int'(pwm_cmd), 127);
        chk("midrst_at_target", int'(at_target), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(target_ready), 1);
        reset = 1'b0;

        // 128 against goal 127 is dropped.
        push(127, 1, 0, 0);
        push(127, 1, 0, 0);
        send(8'd128);
        chk("drop128_ready", int'(target_ready), 1);
        wait_ticks(2);

`ifdef SERVO_WATCHDOG_EN
        // Goal 40, then 50 idle ticks park at centre.
        push(127, 1, 0, 0);
        for (int k = 1; k <= 21; k++) push(127 - 4 * k, 0, 1, 0);
        for (int i = 0; i < 3; i++) push(40, 0, 1, 0);
        for (int i = 0; i < 24; i++) push(40, 1, 0, 0);
        push(40, 1, 0, 1);
        push(44, 0, 1, 1);
        send(8'd40);
        chk("wd_accept_ready", int'(target_ready), 0);
        wait_ticks(51);
        send(8'd60);
        chk("wd_cleared", int'(wdog_flag), 0);
`else
        chk("wdog_tied_low", int'(wdog_flag), 0);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
